// File: rtl/vc_fifo_pkg.sv
// Shared constants and helpers for the virtual-channel FIFO bank.
package vc_fifo_pkg;
  localparam int VC_DATA_SIZE = 10;
  localparam int VC_ADDR_SIZE = 2;
  localparam int VC_NUM_CH    = 4;
  localparam int VC_CH_W      = 2;
  localparam int DEPTH        = 2**VC_ADDR_SIZE;
  localparam int CNT_W        = VC_ADDR_SIZE + 1;

  localparam int ERR_OVF = 0;
  localparam int ERR_UDF = 1;
  localparam int ERR_W   = 2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/vc_fifo_ch.sv
// One virtual-channel FIFO: storage, pointers, occupancy, pause hysteresis
// and sticky overflow/underflow flags.
module vc_fifo_ch
  import vc_fifo_pkg::*;
#(
  parameter int DATA_SIZE = VC_DATA_SIZE,
  parameter int ADDR_SIZE = VC_ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push_i,
  input  logic [DATA_SIZE-1:0] data_i,
  input  logic                 pop_i,
  input  logic [ADDR_SIZE:0]   af_th_i,
  input  logic [ADDR_SIZE:0]   ae_th_i,
  output logic [DATA_SIZE-1:0] head_o,
  output logic [ADDR_SIZE:0]   count_o,
  output logic                 empty_o,
  output logic                 full_o,
  output logic                 pause_o,
  output logic [ERR_W-1:0]     err_o
);
  localparam int                CH_DEPTH = 2**ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] FULL_CNT = (ADDR_SIZE+1)'(CH_DEPTH);
  localparam logic [ADDR_SIZE:0] CNT_ONE  = (ADDR_SIZE+1)'(1);
  localparam logic [ADDR_SIZE-1:0] PTR_ONE = ADDR_SIZE'(1);

  logic [DATA_SIZE-1:0] mem_q [CH_DEPTH];
  logic [ADDR_SIZE-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_SIZE:0]   count_q, count_d;
  logic                 pause_q, pause_d;
  logic [ERR_W-1:0]     err_q, err_d;
  logic                 push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign pause_o = pause_q;
  assign err_o   = err_q;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    // Set has priority so misordered thresholds still assert pause.
    pause_d = pause_q;
    if (count_d >= af_th_i)      pause_d = 1'b1;
    else if (count_d <= ae_th_i) pause_d = 1'b0;
    err_d = err_q;
    if (push_i & full_o)  err_d[ERR_OVF] = 1'b1;
    if (pop_i & empty_o)  err_d[ERR_UDF] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pause_q  <= 1'b0;
      err_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
      pause_q <= pause_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

// File: rtl/vc_fifo_bank.sv
// Bank of NUM_CH virtual-channel FIFOs with a shared channel-selected pop port.
// Define VC_FIFO_FWFT_EN for first-word-fall-through (zero-latency) output.
module vc_fifo_bank
  import vc_fifo_pkg::*;
#(
  parameter int DATA_SIZE = VC_DATA_SIZE,
  parameter int ADDR_SIZE = VC_ADDR_SIZE,
  parameter int NUM_CH    = VC_NUM_CH,
  parameter int CH_W      = VC_CH_W
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_CH-1:0]               push,
  input  logic [NUM_CH*DATA_SIZE-1:0]     data_in,
  input  logic                            pop,
  input  logic [CH_W-1:0]                 pop_ch,
  input  logic [ADDR_SIZE:0]              almost_full_th,
  input  logic [ADDR_SIZE:0]              almost_empty_th,
  output logic [DATA_SIZE-1:0]            data_out,
  output logic                            data_valid,
  output logic [NUM_CH*(ADDR_SIZE+1)-1:0] count,
  output logic [NUM_CH-1:0]               fifo_empty,
  output logic [NUM_CH-1:0]               fifo_full,
  output logic [NUM_CH-1:0]               pause,
  output logic [NUM_CH-1:0]               error_ovf,
  output logic [NUM_CH-1:0]               error_udf
);
  logic [NUM_CH-1:0]    pop_sel;
  logic [DATA_SIZE-1:0] head [NUM_CH];
  logic [ERR_W-1:0]     err [NUM_CH];
  logic [DATA_SIZE-1:0] head_sel;
  logic                 sel_avail;

  // Out-of-range pop_ch matches no channel: no pop, no error, nothing shown.
  always_comb begin
    pop_sel   = '0;
    head_sel  = '0;
    sel_avail = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pop_ch == CH_W'(i)) begin
        pop_sel[i] = pop;
        head_sel   = head[i];
        sel_avail  = ~fifo_empty[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    vc_fifo_ch #(
      .DATA_SIZE(DATA_SIZE),
      .ADDR_SIZE(ADDR_SIZE)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push[g]),
      .data_i  (data_in[g*DATA_SIZE +: DATA_SIZE]),
      .pop_i   (pop_sel[g]),
      .af_th_i (almost_full_th),
      .ae_th_i (almost_empty_th),
      .head_o  (head[g]),
      .count_o (count[g*(ADDR_SIZE+1) +: ADDR_SIZE+1]),
      .empty_o (fifo_empty[g]),
      .full_o  (fifo_full[g]),
      .pause_o (pause[g]),
      .err_o   (err[g])
    );
    assign error_ovf[g] = err[g][ERR_OVF];
    assign error_udf[g] = err[g][ERR_UDF];
  end

`ifdef VC_FIFO_FWFT_EN
  assign data_out   = head_sel;
  assign data_valid = sel_avail;
`else
  logic [DATA_SIZE-1:0] data_out_q;
  logic                 data_valid_q, data_valid_d;

  assign data_valid_d = pop & sel_avail;

  always_ff @(posedge clk) begin
    if (!reset) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      data_valid_q <= data_valid_d;
      if (data_valid_d) data_out_q <= head_sel;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
`endif
endmodule

// File: tb/tb_vc_fifo_bank.sv
// Self-checking bench for vc_fifo_bank: directed plan plus randomized traffic
// against a queue-based reference model.
module tb_vc_fifo_bank;
  localparam int DS = 10;
  localparam int AS = 2;
  localparam int NC = 4;
  localparam int CW = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NC-1:0]     push;
  logic [NC*DS-1:0]  data_in;
  logic              pop;
  logic [CW-1:0]     pop_ch;
  logic [AS:0]       af, ae;
  logic [DS-1:0]     data_out;
  logic              data_valid;
  logic [NC*(AS+1)-1:0] count;
  logic [NC-1:0]     fifo_empty, fifo_full, pause, error_ovf, error_udf;

  vc_fifo_bank #(.DATA_SIZE(DS), .ADDR_SIZE(AS), .NUM_CH(NC), .CH_W(CW)) dut (
    .clk(clk), .reset(reset), .push(push), .data_in(data_in), .pop(pop),
    .pop_ch(pop_ch), .almost_full_th(af), .almost_empty_th(ae),
    .data_out(data_out), .data_valid(data_valid), .count(count),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .pause(pause),
    .error_ovf(error_ovf), .error_udf(error_udf)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  // Reference model: one queue per channel plus sticky/registered state.
  logic [DS-1:0] mq [NC][$];
  logic [NC-1:0] pause_m, ovf_m, udf_m;
  logic [DS-1:0] dout_m;
  logic          dv_m;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    int sz_pre [NC];
    int sz;
    if (!reset) begin
      for (int c = 0; c < NC; c++) mq[c].delete();
      pause_m = '0; ovf_m = '0; udf_m = '0; dout_m = '0; dv_m = 1'b0;
    end else begin
      for (int c = 0; c < NC; c++) sz_pre[c] = mq[c].size();
      dv_m = 1'b0;
      if (pop) begin
        if (sz_pre[pop_ch] == 0) udf_m[pop_ch] = 1'b1;
        else begin
          dv_m = 1'b1;
          dout_m = mq[pop_ch].pop_front();
        end
      end
      for (int c = 0; c < NC; c++)
        if (push[c]) begin
          if (sz_pre[c] == 2**AS) ovf_m[c] = 1'b1;
          else mq[c].push_back(data_in[c*DS +: DS]);
        end
      for (int c = 0; c < NC; c++) begin
        sz = mq[c].size();
        if (sz >= int'(af))      pause_m[c] = 1'b1;
        else if (sz <= int'(ae)) pause_m[c] = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  logic [NC*(AS+1)-1:0] ce;
  logic [NC-1:0]        ee, fe;
  logic                 dve;
  logic [DS-1:0]        doe;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int c = 0; c < NC; c++) begin
        ce[c*(AS+1) +: AS+1] = (AS+1)'(mq[c].size());
        ee[c] = (mq[c].size() == 0);
        fe[c] = (mq[c].size() == 2**AS);
      end
`ifdef VC_FIFO_FWFT_EN
      dve = (mq[pop_ch].size() != 0);
      doe = dve ? mq[pop_ch][0] : data_out;
`else
      dve = dv_m;
      doe = dout_m;
`endif
      chk("count", 64'(count), 64'(ce));
      chk("fifo_empty", 64'(fifo_empty), 64'(ee));
      chk("fifo_full", 64'(fifo_full), 64'(fe));
      chk("pause", 64'(pause), 64'(pause_m));
      chk("error_ovf", 64'(error_ovf), 64'(ovf_m));
      chk("error_udf", 64'(error_udf), 64'(udf_m));
      chk("data_valid", 64'(data_valid), 64'(dve));
      if (dve) chk("data_out", 64'(data_out), 64'(doe));
    end
  end

  task automatic pop_expect(input int ch, input logic [DS-1:0] exp);
    pop_ch = CW'(ch);
`ifdef VC_FIFO_FWFT_EN
    #1;
    chk("pop_head", 64'(data_out), 64'(exp));
    chk("pop_head_valid", 64'(data_valid), 64'(1));
`endif
    pop = 1'b1;
    step();
    pop = 1'b0;
    push = '0;
`ifndef VC_FIFO_FWFT_EN
    chk("pop_data", 64'(data_out), 64'(exp));
    chk("pop_valid", 64'(data_valid), 64'(1));
`endif
  endtask

  initial begin
    reset = 1'b0; push = 4'hF; data_in = 40'({$urandom, $urandom});
    pop = 1'b0; pop_ch = '0; af = 3'd3; ae = 3'd1;
    step();
    chk_en = 1'b1;
    step();
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_empty", 64'(fifo_empty), 64'(4'hF));
    chk("rst_pause", 64'(pause), 64'(0));
    chk("rst_err", 64'({error_ovf, error_udf}), 64'(0));
    chk("rst_dv", 64'(data_valid), 64'(0));

    // Fill and drain ch0
    reset = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      push = 4'b0001; data_in[9:0] = 10'(k); step();
    end
    push = '0;
    chk("fill_full0", 64'(fifo_full[0]), 64'(1));
    chk("fill_cnt0", 64'(count[2:0]), 64'(4));
    push = 4'b0001; data_in[9:0] = 10'h3FF; step(); push = '0;
    chk("ovf0", 64'(error_ovf[0]), 64'(1));
    chk("ovf_cnt0", 64'(count[2:0]), 64'(4));
    for (int k = 1; k <= 4; k++) pop_expect(0, 10'(k));

    // Pause hysteresis on ch2 (af=3, ae=1)
    for (int k = 0; k < 3; k++) begin
      push = 4'b0100; data_in[29:20] = 10'(10'h200 + k); step();
    end
    push = '0;
    chk("p_cnt3", 64'(count[8:6]), 64'(3));
    chk("p_set", 64'(pause[2]), 64'(1));
    pop_expect(2, 10'h200);
    chk("p_hold", 64'(pause[2]), 64'(1));
    pop_expect(2, 10'h201);
    chk("p_clr", 64'(pause[2]), 64'(0));

    // Simultaneous push+pop on ch1
    push = 4'b0010; data_in[19:10] = 10'h0A0; step();
    push = 4'b0010; data_in[19:10] = 10'h0A1; step();
    push = 4'b0010; data_in[19:10] = 10'h0A2;
    pop_expect(1, 10'h0A0);
    chk("pp_cnt1", 64'(count[5:3]), 64'(2));
    pop_expect(1, 10'h0A1);
    pop_expect(1, 10'h0A2);

    // Pop of empty ch3 with simultaneous push: no bypass
    pop_ch = 2'd3;
`ifdef VC_FIFO_FWFT_EN
    #1 chk("udf_dv_pre", 64'(data_valid), 64'(0));
`endif
    push = 4'b1000; data_in[39:30] = 10'h155; pop = 1'b1; step();
    push = '0; pop = 1'b0;
    chk("udf3", 64'(error_udf[3]), 64'(1));
    chk("udf_cnt3", 64'(count[11:9]), 64'(1));
`ifndef VC_FIFO_FWFT_EN
    chk("udf_dv", 64'(data_valid), 64'(0));
`endif

    // Isolation
    pop_expect(3, 10'h155);
    push = 4'hF; data_in = {10'h103, 10'h102, 10'h101, 10'h100}; step(); push = '0;
    pop_expect(3, 10'h103);
    pop_expect(1, 10'h101);
    chk("iso_cnt", 64'(count), 64'({3'd0, 3'd2, 3'd0, 3'd1}));
    chk("iso_ovf", 64'(error_ovf), 64'(4'b0001));
    chk("iso_udf", 64'(error_udf), 64'(4'b1000));

    // Wrap-around on ch0
    reset = 1'b0; step(); reset = 1'b1;
    push = 4'b0001; data_in[9:0] = 10'd0; step(); push = '0;
    for (int k = 1; k < 12; k++) begin
      push = 4'b0001; data_in[9:0] = 10'(k);
      pop_expect(0, 10'(k - 1));
      chk("wrap_cnt", 64'(count[2:0] <= 3'd1), 64'(1));
    end
    pop_expect(0, 10'd11);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (n % 100 == 0) begin
        af = 3'($urandom_range(4, 0));
        ae = 3'($urandom_range(4, 0));
      end
      reset   = ($urandom_range(199, 0) != 0);
      push    = 4'($urandom);
      data_in = 40'({$urandom, $urandom});
      pop     = ($urandom_range(9, 0) < 6);
      pop_ch  = 2'($urandom);
      step();
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
